// File: rtl/param_sync_fifo_if.sv
// Handshake and status bundle for param_sync_fifo.
// The master drives requests and write data, and the slave (the FIFO)
// returns read data, the flags and the occupancy count.
interface param_sync_fifo_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 32
);
    localparam int ADDR_W = $clog2(DEPTH);

    logic                  flush;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  valid;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic                  overflow;
    logic                  underflow;
    logic [ADDR_W:0]       count;

    modport master (
        output flush, wr_en, data_in, rd_en,
        input  data_out, valid, full, empty, almost_full, almost_empty,
               overflow, underflow, count
    );

    modport slave (
        input  flush, wr_en, data_in, rd_en,
        output data_out, valid, full, empty, almost_full, almost_empty,
               overflow, underflow, count
    );
endinterface

// File: rtl/param_sync_fifo.sv
// Single-clock FIFO with a parameterised width and depth, almost-full and
// almost-empty thresholds, and a choice of registered or first-word-fall-through
// read data.
// The flags are decoded from the registered count, so they carry no extra
// latency. Requests are accepted using only those registered flags.
module param_sync_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 32,
    parameter int AF_THRESH  = DEPTH - 2,
    parameter int AE_THRESH  = 2,
    parameter bit FWFT       = 1'b0
) (
    input logic clk,
    input logic rst,
    param_sync_fifo_if.slave bus
);
    localparam int ADDR_W = $clog2(DEPTH);

    localparam logic [ADDR_W:0]   CNT_FULL = DEPTH[ADDR_W:0];
    localparam logic [ADDR_W:0]   AF_LVL   = AF_THRESH[ADDR_W:0];
    localparam logic [ADDR_W:0]   AE_LVL   = AE_THRESH[ADDR_W:0];
    localparam logic [ADDR_W:0]   CNT_ONE  = 1;
    localparam logic [ADDR_W-1:0] PTR_ONE  = 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_W-1:0]     wr_ptr;
    logic [ADDR_W-1:0]     rd_ptr;
    logic [ADDR_W:0]       count;
    logic                  full;
    logic                  empty;
    logic                  wr_accept;
    logic                  rd_accept;
    logic                  overflow;
    logic                  underflow;

    // Flag decode and request acceptance, based only on the registered count.
    // NOTE: every signal gets a value on every path, so no latch is inferred.
    always_comb begin
        full      = (count == CNT_FULL);
        empty     = (count == '0);
        wr_accept = bus.wr_en & ~full  & ~bus.flush;
        rd_accept = bus.rd_en & ~empty & ~bus.flush;
    end

    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.almost_full  = (count >= AF_LVL);
    assign bus.almost_empty = (count <= AE_LVL);
    assign bus.count        = count;
    assign bus.overflow     = overflow;
    assign bus.underflow    = underflow;

    // Storage write port. A rejected write leaves memory untouched.
    // NOTE: memory is left out of reset on purpose. Clearing the pointers and
    // count is enough to discard stored words, and a reset-free array maps
    // onto RAM.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_ptr] <= bus.data_in;
        end
    end

    // Pointer and occupancy tracking. Flush takes priority over any request.
    // NOTE: sequential state uses non-blocking assignments so that every
    // register samples the values from before the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (bus.flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_accept) wr_ptr <= wr_ptr + PTR_ONE;
            if (rd_accept) rd_ptr <= rd_ptr + PTR_ONE;
            case ({wr_accept, rd_accept})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // One-cycle error pulses for rejected writes and rejected reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= bus.wr_en & full  & ~bus.flush;
            underflow <= bus.rd_en & empty & ~bus.flush;
        end
    end

    generate
        if (FWFT) begin : g_fwft
            // The head word is shown directly. It is zeroed while empty so
            // that stale or uninitialised memory never reaches the output.
            assign bus.data_out = empty ? '0 : mem[rd_ptr];
            assign bus.valid    = ~empty;
        end else begin : g_reg
            logic [DATA_WIDTH-1:0] dout_q;
            logic                  valid_q;

            // Registered read: latch the head on an accepted pop and raise
            // valid for one cycle. The data holds between reads.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    dout_q  <= '0;
                    valid_q <= 1'b0;
                end else if (bus.flush) begin
                    valid_q <= 1'b0;
                end else begin
                    valid_q <= rd_accept;
                    if (rd_accept) dout_q <= mem[rd_ptr];
                end
            end

            assign bus.data_out = dout_q;
            assign bus.valid    = valid_q;
        end
    endgenerate
endmodule

// File: tb/tb_param_sync_fifo.sv
// Directed testbench for param_sync_fifo. It drives one registered-read
// instance and one first-word-fall-through instance, both DEPTH=8.
module tb_param_sync_fifo;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    param_sync_fifo_if #(.DATA_WIDTH(8), .DEPTH(8)) a_if ();
    param_sync_fifo_if #(.DATA_WIDTH(8), .DEPTH(8)) b_if ();

    param_sync_fifo #(
        .DATA_WIDTH(8), .DEPTH(8), .AF_THRESH(6), .AE_THRESH(2), .FWFT(1'b0)
    ) dut_reg (
        .clk(clk), .rst(rst), .bus(a_if)
    );

    param_sync_fifo #(
        .DATA_WIDTH(8), .DEPTH(8), .AF_THRESH(6), .AE_THRESH(2), .FWFT(1'b1)
    ) dut_fwft (
        .clk(clk), .rst(rst), .bus(b_if)
    );

    task automatic check(input string tag, input logic [31:0] got, input int exp);
        checks++;
        if (got !== 32'(exp)) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance past one rising edge. Outputs are sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        a_if.flush = 1'b0; a_if.wr_en = 1'b0; a_if.rd_en = 1'b0; a_if.data_in = '0;
        b_if.flush = 1'b0; b_if.wr_en = 1'b0; b_if.rd_en = 1'b0; b_if.data_in = '0;
        #2;
        check("rst_empty",    32'(a_if.empty), 1);
        check("rst_ae",       32'(a_if.almost_empty), 1);
        check("rst_full",     32'(a_if.full), 0);
        check("rst_af",       32'(a_if.almost_full), 0);
        check("rst_count",    32'(a_if.count), 0);
        check("rst_valid",    32'(a_if.valid), 0);
        check("rst_dout",     32'(a_if.data_out), 0);
        check("rst_ovf",      32'(a_if.overflow), 0);
        check("rst_unf",      32'(a_if.underflow), 0);
        check("rst_b_valid",  32'(b_if.valid), 0);
        check("rst_b_dout",   32'(b_if.data_out), 0);
        #1 rst = 1'b0;

        // Fill 1..8 and track the threshold flags at every level.
        check("lvl0_ae", 32'(a_if.almost_empty), 1);
        check("lvl0_af", 32'(a_if.almost_full), 0);
        for (int i = 1; i <= 8; i++) begin
            a_if.wr_en = 1'b1; a_if.data_in = 8'(i);
            step();
            check("fill_count", 32'(a_if.count), i);
            check("fill_ae",    32'(a_if.almost_empty), (i <= 2) ? 1 : 0);
            check("fill_af",    32'(a_if.almost_full),  (i >= 6) ? 1 : 0);
        end
        check("full_flag", 32'(a_if.full), 1);

        // Write while full: one overflow pulse, and nothing stored.
        a_if.data_in = 8'hFF;
        step();
        check("ovf_pulse", 32'(a_if.overflow), 1);
        check("ovf_count", 32'(a_if.count), 8);
        a_if.wr_en = 1'b0;
        step();
        check("ovf_clear", 32'(a_if.overflow), 0);

        // Drain: each read gives a one-cycle valid, and the data holds after.
        for (int i = 1; i <= 8; i++) begin
            a_if.rd_en = 1'b1;
            step();
            check("rd_valid", 32'(a_if.valid), 1);
            check("rd_data",  32'(a_if.data_out), i);
            a_if.rd_en = 1'b0;
            step();
            check("rd_valid_drop", 32'(a_if.valid), 0);
            check("rd_data_hold",  32'(a_if.data_out), i);
        end
        check("drain_empty", 32'(a_if.empty), 1);
        check("drain_count", 32'(a_if.count), 0);

        // Read while empty.
        a_if.rd_en = 1'b1;
        step();
        check("unf_pulse", 32'(a_if.underflow), 1);
        check("unf_count", 32'(a_if.count), 0);
        check("unf_valid", 32'(a_if.valid), 0);
        a_if.rd_en = 1'b0;
        step();
        check("unf_clear", 32'(a_if.underflow), 0);

        // Prime with 0x10..0x13, then stream 20 cycles across pointer wrap.
        for (int k = 0; k < 4; k++) begin
            a_if.wr_en = 1'b1; a_if.data_in = 8'(16 + k);
            step();
        end
        check("prime_count", 32'(a_if.count), 4);
        for (int k = 0; k < 20; k++) begin
            a_if.wr_en = 1'b1; a_if.rd_en = 1'b1; a_if.data_in = 8'(20 + k);
            step();
            check("stream_count", 32'(a_if.count), 4);
            check("stream_valid", 32'(a_if.valid), 1);
            check("stream_data",  32'(a_if.data_out), 16 + k);
        end
        a_if.rd_en = 1'b0; a_if.data_in = 8'h28;
        step();
        a_if.wr_en = 1'b0;
        check("pre_flush_count", 32'(a_if.count), 5);

        // Flush overrides simultaneous requests.
        a_if.flush = 1'b1; a_if.wr_en = 1'b1; a_if.rd_en = 1'b1;
        step();
        check("flush_count", 32'(a_if.count), 0);
        check("flush_empty", 32'(a_if.empty), 1);
        check("flush_valid", 32'(a_if.valid), 0);
        check("flush_ovf",   32'(a_if.overflow), 0);
        check("flush_unf",   32'(a_if.underflow), 0);
        a_if.flush = 1'b0; a_if.wr_en = 1'b0; a_if.rd_en = 1'b0;
        step();
        check("post_flush_count", 32'(a_if.count), 0);
        check("post_flush_unf",   32'(a_if.underflow), 0);

        // Asynchronous reset in the middle of a fill. data_out still holds 0x23.
        for (int k = 0; k < 3; k++) begin
            a_if.wr_en = 1'b1; a_if.data_in = 8'(48 + k);
            step();
        end
        a_if.wr_en = 1'b0;
        check("midfill_count", 32'(a_if.count), 3);
        check("midfill_dout",  32'(a_if.data_out), 8'h23);
        #2 rst = 1'b1;
        #1;
        check("arst_count", 32'(a_if.count), 0);
        check("arst_empty", 32'(a_if.empty), 1);
        check("arst_ae",    32'(a_if.almost_empty), 1);
        check("arst_full",  32'(a_if.full), 0);
        check("arst_dout",  32'(a_if.data_out), 0);
        check("arst_valid", 32'(a_if.valid), 0);
        #1 rst = 1'b0;

        // First edge after reset accepts a write, and the old words are gone.
        a_if.wr_en = 1'b1; a_if.data_in = 8'h55;
        step();
        a_if.wr_en = 1'b0;
        check("post_rst_count", 32'(a_if.count), 1);
        a_if.rd_en = 1'b1;
        step();
        a_if.rd_en = 1'b0;
        check("post_rst_data",  32'(a_if.data_out), 8'h55);
        check("post_rst_valid", 32'(a_if.valid), 1);

        // FWFT: a word written into an empty FIFO appears without any read.
        b_if.wr_en = 1'b1; b_if.data_in = 8'hA5;
        step();
        b_if.wr_en = 1'b0;
        check("fwft_valid", 32'(b_if.valid), 1);
        check("fwft_data",  32'(b_if.data_out), 8'hA5);
        b_if.rd_en = 1'b1;
        step();
        b_if.rd_en = 1'b0;
        check("fwft_pop_empty", 32'(b_if.empty), 1);
        check("fwft_pop_valid", 32'(b_if.valid), 0);

        // FWFT: after a pop, the next word becomes the head.
        b_if.wr_en = 1'b1; b_if.data_in = 8'h11;
        step();
        b_if.data_in = 8'h22;
        step();
        b_if.wr_en = 1'b0;
        check("fwft_head0", 32'(b_if.data_out), 8'h11);
        b_if.rd_en = 1'b1;
        step();
        check("fwft_head1", 32'(b_if.data_out), 8'h22);
        check("fwft_head1_valid", 32'(b_if.valid), 1);
        step();
        b_if.rd_en = 1'b0;
        check("fwft_drain_empty", 32'(b_if.empty), 1);
        check("fwft_drain_valid", 32'(b_if.valid), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
